// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: major opcodes, funct7 values and immediate formats.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: selects the RV32I immediate layout and
// sign-extends it from bit 31 of the instruction to XLEN.
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Signed size cast replicates bit 31 when XLEN is wider than 32.
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer (head + skid).
// Optional RV32M decode is enabled by defining RV32M_DECODE_EN.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal,
  output logic            out_is_muldiv,
  output logic [2:0]      out_mdu_op
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;
    logic            is_muldiv;
    logic [2:0]      mdu_op;
  } bundle_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  imm_fmt_e        fmt;
  logic [XLEN-1:0] dec_imm;
  logic            legal_op;
  logic            bad_funct;
  bundle_t         dec;

  bundle_t head_d, head_q;
  bundle_t skid_d, skid_q;
  logic    head_valid_d, head_valid_q;
  logic    skid_valid_d, skid_valid_q;
  logic    in_fire;
  logic    out_fire;

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];

  always_comb begin
    fmt = IMM_NONE;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: fmt = IMM_I;
      OP_STORE:                            fmt = IMM_S;
      OP_BRANCH:                           fmt = IMM_B;
      OP_LUI, OP_AUIPC:                    fmt = IMM_U;
      OP_JAL:                              fmt = IMM_J;
      default:                             fmt = IMM_NONE;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (dec_imm)
  );

  // Field decode and legality; illegal words still carry their decoded fields.
  always_comb begin
    dec        = '0;
    legal_op   = 1'b1;
    bad_funct  = 1'b0;
    dec.pc     = in_pc;
    dec.opcode = opcode;
    dec.rd     = in_instr[11:7];
    dec.rs1    = in_instr[19:15];
    dec.funct3 = funct3;
    dec.imm    = dec_imm;
    case (opcode)
      OP_R: begin
        dec.rs2    = in_instr[24:20];
        dec.funct7 = funct7;
        if (funct7 == F7_MULDIV) begin
`ifdef RV32M_DECODE_EN
          dec.is_muldiv = 1'b1;
          dec.mdu_op    = funct3;
`else
          bad_funct = 1'b1;
`endif
        end else if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
          bad_funct = 1'b1;
        end
      end
      OP_IMM: begin
        if ((funct3 == 3'b001) && (funct7 != F7_BASE)) begin
          bad_funct = 1'b1;
        end
        if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT)) begin
          bad_funct = 1'b1;
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
      end
      OP_STORE: begin
        dec.rd    = '0;
        dec.rs2   = in_instr[24:20];
        bad_funct = (funct3 > 3'd2);
      end
      OP_BRANCH: begin
        dec.rd    = '0;
        dec.rs2   = in_instr[24:20];
        bad_funct = (funct3[2:1] == 2'b01);
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        dec.rs1    = '0;
        dec.funct3 = '0;
      end
      default: legal_op = 1'b0;
    endcase
    dec.illegal = (in_instr[1:0] != 2'b11) | ~legal_op | bad_funct;
  end

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = head_valid_q & out_ready;

  // Skid entry only fills while the head is stalled; it refills the head first
  // on the next output transfer, which keeps the pair in strict FIFO order.
  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      head_d       = '0;
      skid_d       = '0;
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || out_fire) begin
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        head_d       = dec;
        head_valid_d = 1'b1;
      end else begin
        head_d       = '0;
        head_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid     = head_valid_q;
  assign out_pc        = head_q.pc;
  assign out_opcode    = head_q.opcode;
  assign out_rd        = head_q.rd;
  assign out_rs1       = head_q.rs1;
  assign out_rs2       = head_q.rs2;
  assign out_funct3    = head_q.funct3;
  assign out_funct7    = head_q.funct7;
  assign out_imm       = head_q.imm;
  assign out_illegal   = head_q.illegal;
  assign out_is_muldiv = head_q.is_muldiv;
  assign out_mdu_op    = head_q.mdu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: random traffic, stalls and flushes checked
// against a behavioural RV32I decode model; honours RV32M_DECODE_EN.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    logic        is_muldiv;
    logic [2:0]  mdu_op;
  } exp_t;

  localparam logic [6:0] O_OP     = 7'h33;
  localparam logic [6:0] O_IMM    = 7'h13;
  localparam logic [6:0] O_LOAD   = 7'h03;
  localparam logic [6:0] O_STORE  = 7'h23;
  localparam logic [6:0] O_BRANCH = 7'h63;
  localparam logic [6:0] O_JAL    = 7'h6F;
  localparam logic [6:0] O_JALR   = 7'h67;
  localparam logic [6:0] O_LUI    = 7'h37;
  localparam logic [6:0] O_AUIPC  = 7'h17;
  localparam logic [6:0] O_SYS    = 7'h73;

`ifdef RV32M_DECODE_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic        out_is_muldiv;
  logic [2:0]  out_mdu_op;

  exp_t q[$];
  int   nCompared = 0;
  int   nMismatched = 0;
  bit   monEn = 1'b0;

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_opcode    (out_opcode),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_funct3    (out_funct3),
    .out_funct7    (out_funct7),
    .out_imm       (out_imm),
    .out_illegal   (out_illegal),
    .out_is_muldiv (out_is_muldiv),
    .out_mdu_op    (out_mdu_op)
  );

  always #5 clk = ~clk;

  // Reference decode built directly from the RV32I field and immediate rules.
  function automatic exp_t model(logic [31:0] ins, logic [31:0] pc);
    exp_t       e;
    int         s;
    int         t;
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    bit         known;
    bit         bad;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    s  = ins;
    e  = '0;
    e.pc     = pc;
    e.opcode = op;
    known = op inside {O_OP, O_IMM, O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_LUI, O_AUIPC, O_SYS};
    e.rd     = (op == O_STORE || op == O_BRANCH) ? 5'd0 : ins[11:7];
    e.rs1    = (op == O_LUI || op == O_AUIPC || op == O_JAL) ? 5'd0 : ins[19:15];
    e.rs2    = (op == O_OP || op == O_STORE || op == O_BRANCH) ? ins[24:20] : 5'd0;
    e.funct3 = (op == O_LUI || op == O_AUIPC || op == O_JAL) ? 3'd0 : f3;
    e.funct7 = (op == O_OP) ? f7 : 7'd0;
    case (op)
      O_IMM, O_LOAD, O_JALR, O_SYS: begin
        t = s >>> 20;
        e.imm = t;
      end
      O_STORE: begin
        t = s >>> 25;
        e.imm = t * 32 + 32'(ins[11:7]);
      end
      O_BRANCH: begin
        t = s >>> 31;
        e.imm = t * 4096 + 32'(ins[7]) * 2048 + 32'(ins[30:25]) * 32 + 32'(ins[11:8]) * 2;
      end
      O_LUI, O_AUIPC: e.imm = ins & 32'hFFFFF000;
      O_JAL: begin
        t = s >>> 31;
        e.imm = t * 1048576 + 32'(ins[19:12]) * 4096 + 32'(ins[20]) * 2048 + 32'(ins[30:21]) * 2;
      end
      default: e.imm = 32'd0;
    endcase
    bad = 1'b0;
    if (op == O_BRANCH && (f3 == 3'd2 || f3 == 3'd3)) bad = 1'b1;
    if (op == O_STORE && f3 > 3'd2) bad = 1'b1;
    if (op == O_OP && !(f7 == 7'h00 || f7 == 7'h20 || (MULDIV_EN && f7 == 7'h01))) bad = 1'b1;
    if (op == O_IMM && f3 == 3'd1 && f7 != 7'h00) bad = 1'b1;
    if (op == O_IMM && f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)) bad = 1'b1;
    e.illegal   = (ins[1:0] != 2'b11) || !known || bad;
    e.is_muldiv = MULDIV_EN && (op == O_OP) && (f7 == 7'h01);
    e.mdu_op    = e.is_muldiv ? f3 : 3'd0;
    return e;
  endfunction

  function automatic logic [31:0] genInstr();
    logic [31:0] ins;
    logic [6:0]  ops[10];
    int          sel;
    ops = '{O_OP, O_IMM, O_LOAD, O_STORE, O_BRANCH, O_JAL, O_JALR, O_LUI, O_AUIPC, O_SYS};
    ins = $urandom;
    sel = $urandom_range(0, 11);
    if (sel < 10) ins[6:0] = ops[sel];
    if (ins[6:0] == O_OP || ins[6:0] == O_IMM) begin
      case ($urandom_range(0, 3))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        2:       ins[31:25] = 7'h01;
        default: ins[31:25] = ins[31:25];
      endcase
    end
    return ins;
  endfunction

  function automatic exp_t actualBundle();
    return {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
            out_imm, out_illegal, out_is_muldiv, out_mdu_op};
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(exp_t e);
    check($sformatf("bundle pc=%08h", e.pc), 128'(actualBundle()), 128'(e));
  endtask

  // One cycle of stimulus: verify occupancy-derived handshakes, drive, then
  // push the expected bundle if the instruction will be accepted.
  task automatic applyStimulus(bit v, logic [31:0] ins, logic [31:0] pc, bit rdy, bit fl);
    @(posedge clk);
    #1;
    check("in_ready", 128'(in_ready), 128'(q.size() < 2));
    check("out_valid", 128'(out_valid), 128'(q.size() > 0));
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1;
    if (v && in_ready && !fl) q.push_back(model(ins, pc));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (monEn && rst_n) begin
        if (flush) begin
          q.delete();
        end else if (out_valid) begin
          if (q.size() == 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL unexpected_out: got pc=%08h required no output", out_pc);
          end else begin
            checkOutput(q[0]);
            if (out_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    bit          v;
    bit          rdy;
    bit          fl;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    pc        = 32'h0000_1000;
    #12;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_bundle", 128'(actualBundle()), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    monEn = 1'b1;

    applyStimulus(1, 32'hFFF00093, 32'h100, 1, 0);
    applyStimulus(1, 32'h0020A423, 32'h104, 1, 0);
    applyStimulus(1, 32'hFE208EE3, 32'h108, 1, 0);
    applyStimulus(1, 32'h02208033, 32'h10C, 1, 0);
    applyStimulus(1, 32'h00000000, 32'h110, 1, 0);
    applyStimulus(1, 32'h123452B7, 32'h114, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    applyStimulus(1, 32'h00100093, 32'h200, 0, 0);
    applyStimulus(1, 32'h00200113, 32'h204, 0, 0);
    applyStimulus(1, 32'h00300193, 32'h208, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    applyStimulus(1, 32'h00400213, 32'h300, 0, 0);
    applyStimulus(1, 32'h00500293, 32'h304, 0, 0);
    applyStimulus(1, 32'h00600313, 32'h308, 0, 1);
    applyStimulus(1, 32'h00700393, 32'h30C, 1, 0);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 39) == 0);
      pc  = pc + 4;
      applyStimulus(v, genInstr(), pc, rdy, fl);
    end

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      applyStimulus(0, 32'h0, 32'h0, 1, 0);
    end
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    if (q.size() != 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain_timeout: got %0d held required 0", q.size());
    end

    applyStimulus(1, 32'h00800413, 32'h400, 0, 0);
    applyStimulus(1, 32'h00900493, 32'h404, 0, 0);
    applyStimulus(0, 32'h0, 32'h0, 0, 0);
    @(posedge clk);
    #3;
    monEn = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(out_valid), 128'(0));
    check("async_rst_in_ready", 128'(in_ready), 128'(1));
    check("async_rst_bundle", 128'(actualBundle()), 128'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
